read_counter_bank: RTL and testbench

Parametrised multi-channel successor to the single-gimbal read counter. It holds NCH independent angle read counters, each stepped up or down by its error-angle logic. Every step is also logged as a signed pending increment, which is paced out to the AGC as rate-limited plus/minus count pulses. Zeroing is per channel. The block sits between the per-channel error-angle logic and the AGC counter interface, and replaces the separate per-gimbal read counters.

---
 rtl/read_counter_bank.sv | 119 +++++++++++
 tb/tb_read_counter_bank.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/read_counter_bank.sv
// Multi-channel angle read counter bank. Each channel's up/down steps are counted
// and also paced out to the AGC as rate-limited plus/minus pulses.
module read_counter_bank #(
    parameter int NCH       = 3,
    parameter int WIDTH     = 16,
    parameter int PEND_W    = 4,
    parameter int PULSE_DIV = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         up,
    input  logic [NCH-1:0]         dn,
    input  logic [NCH-1:0]         cduz,
    output logic [NCH*WIDTH-1:0]   count,
    output logic [NCH-1:0]         pulse_p,
    output logic [NCH-1:0]         pulse_m,
    output logic [NCH-1:0]         sat
);

    localparam int TW = $clog2(PULSE_DIV);
    localparam logic [TW-1:0] TMAX = TW'(PULSE_DIV - 1);
    // Two guard bits hold pending + step - emit without overflow before clamping.
    localparam int EW = PEND_W + 2;
    localparam logic signed [EW-1:0] PMAX = EW'(2 ** (PEND_W - 1) - 1);
    localparam logic signed [EW-1:0] NMAX = -PMAX;

    logic [TW-1:0]                  timer_q, timer_d;
    logic                           tick;
    logic [NCH-1:0][WIDTH-1:0]      count_q, count_d;
    logic [NCH-1:0][PEND_W-1:0]     pend_q, pend_d;
    logic [NCH-1:0]                 sat_q, sat_d;
    logic [NCH-1:0]                 pulse_p_q, pulse_p_d;
    logic [NCH-1:0]                 pulse_m_q, pulse_m_d;
    logic [NCH-1:0]                 step_up, step_dn;
    logic signed [EW-1:0]           pend_ext [NCH];
    logic signed [EW-1:0]           step_s   [NCH];
    logic signed [EW-1:0]           emit_s   [NCH];
    logic signed [EW-1:0]           raw_s    [NCH];

    always_comb begin
        tick    = (timer_q == TMAX);
        timer_d = tick ? '0 : timer_q + TW'(1);
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            step_up[i]   = up[i] & ~dn[i];
            step_dn[i]   = dn[i] & ~up[i];
            pend_ext[i]  = {{2{pend_q[i][PEND_W-1]}}, pend_q[i]};
            step_s[i]    = '0;
            emit_s[i]    = '0;
            pulse_p_d[i] = 1'b0;
            pulse_m_d[i] = 1'b0;
            count_d[i]   = count_q[i];
            pend_d[i]    = pend_q[i];
            sat_d[i]     = sat_q[i];

            if (step_up[i]) begin
                step_s[i]  = EW'(1);
                count_d[i] = count_q[i] + WIDTH'(1);
            end else if (step_dn[i]) begin
                step_s[i]  = '1;
                count_d[i] = count_q[i] - WIDTH'(1);
            end

            if (tick && !cduz[i]) begin
                if (!pend_q[i][PEND_W-1] && (|pend_q[i])) begin
                    emit_s[i]    = EW'(1);
                    pulse_p_d[i] = 1'b1;
                end else if (pend_q[i][PEND_W-1]) begin
                    emit_s[i]    = '1;
                    pulse_m_d[i] = 1'b1;
                end
            end

            raw_s[i] = pend_ext[i] + step_s[i] - emit_s[i];
            // Overflow drops only the AGC-side log; the read counter keeps the step.
            if (raw_s[i] > PMAX) begin
                pend_d[i] = PMAX[PEND_W-1:0];
                sat_d[i]  = 1'b1;
            end else if (raw_s[i] < NMAX) begin
                pend_d[i] = NMAX[PEND_W-1:0];
                sat_d[i]  = 1'b1;
            end else begin
                pend_d[i] = raw_s[i][PEND_W-1:0];
            end

            if (cduz[i]) begin
                count_d[i] = '0;
                pend_d[i]  = '0;
                sat_d[i]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q   <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            sat_q     <= '0;
            pulse_p_q <= '0;
            pulse_m_q <= '0;
        end else begin
            timer_q   <= timer_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            sat_q     <= sat_d;
            pulse_p_q <= pulse_p_d;
            pulse_m_q <= pulse_m_d;
        end
    end

    assign count   = count_q;
    assign pulse_p = pulse_p_q;
    assign pulse_m = pulse_m_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_read_counter_bank.sv
// Self-checking bench for read_counter_bank: constant vector table, directed
// multi-cycle sequences and random stimulus against a behavioural channel model.
module tb_read_counter_bank;

    localparam int NCH  = 3;
    localparam int PD   = 16;
    localparam int PMAX = 7;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [2:0]     up, dn, cduz;
    logic [47:0]    count;
    logic [2:0]     pulse_p, pulse_m, sat;

    read_counter_bank dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .up      (up),
        .dn      (dn),
        .cduz    (cduz),
        .count   (count),
        .pulse_p (pulse_p),
        .pulse_m (pulse_m),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: plain integers per channel, cycle count since reset.
    int         m_cnt  [NCH];
    int         m_pend [NCH];
    logic [2:0] m_pp, m_pm, m_sat;
    int         cyc;
    bit         last_tick;
    int         np [NCH];
    int         nm [NCH];

    typedef struct {
        logic [2:0]  u;
        logic [2:0]  d;
        logic [2:0]  z;
        logic [47:0] exp_count;
        logic [2:0]  exp_sat;
    } vec_t;

    vec_t vecs [7];

    task automatic compare(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_pend[i] = 0;
        end
        m_pp = '0;
        m_pm = '0;
        m_sat = '0;
        cyc = 0;
        last_tick = 0;
    endtask

    task automatic model_update(input logic [2:0] u, input logic [2:0] d, input logic [2:0] z);
        bit t;
        int s, e, raw;
        t = (cyc % PD) == PD - 1;
        for (int i = 0; i < NCH; i++) begin
            m_pp[i] = 1'b0;
            m_pm[i] = 1'b0;
            if (z[i]) begin
                m_cnt[i]  = 0;
                m_pend[i] = 0;
                m_sat[i]  = 1'b0;
            end else begin
                s = (u[i] && !d[i]) ? 1 : ((d[i] && !u[i]) ? -1 : 0);
                m_cnt[i] = (m_cnt[i] + s + 65536) % 65536;
                e = 0;
                if (t) e = (m_pend[i] > 0) ? 1 : ((m_pend[i] < 0) ? -1 : 0);
                m_pp[i] = (e == 1);
                m_pm[i] = (e == -1);
                raw = m_pend[i] + s - e;
                if (raw > PMAX) begin
                    m_pend[i] = PMAX;
                    m_sat[i]  = 1'b1;
                end else if (raw < -PMAX) begin
                    m_pend[i] = -PMAX;
                    m_sat[i]  = 1'b1;
                end else begin
                    m_pend[i] = raw;
                end
            end
        end
        last_tick = t;
        cyc++;
    endtask

    task automatic check_output();
        logic [47:0] exp_c;
        exp_c = {16'(m_cnt[2]), 16'(m_cnt[1]), 16'(m_cnt[0])};
        compare("count", count, exp_c);
        compare("pulse_p", {45'd0, pulse_p}, {45'd0, m_pp});
        compare("pulse_m", {45'd0, pulse_m}, {45'd0, m_pm});
        compare("sat", {45'd0, sat}, {45'd0, m_sat});
        compare("pulse_excl", {45'd0, pulse_p & pulse_m}, 48'd0);
        for (int i = 0; i < NCH; i++) begin
            np[i] += int'(pulse_p[i]);
            nm[i] += int'(pulse_m[i]);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] u, input logic [2:0] d, input logic [2:0] z);
        up = u;
        dn = d;
        cduz = z;
        @(posedge clk);
        model_update(u, d, z);
        @(negedge clk);
        check_output();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(3'b000, 3'b000, 3'b000);
    endtask

    task automatic clear_tally();
        for (int i = 0; i < NCH; i++) begin
            np[i] = 0;
            nm[i] = 0;
        end
    endtask

    task automatic wait_after_tick();
        for (int k = 0; k <= PD && !last_tick; k++) idle(1);
        if (!last_tick) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL tick_wait: got no tick expected tick within %0d cycles", PD + 1);
        end
    endtask

    task automatic hold_reset_cycle(input logic [2:0] u, input logic [2:0] d, input logic [2:0] z);
        up = u;
        dn = d;
        cduz = z;
        @(posedge clk);
        @(negedge clk);
        compare("rst_count", count, 48'd0);
        compare("rst_pulses", {42'd0, pulse_p, pulse_m}, 48'd0);
        compare("rst_sat", {45'd0, sat}, 48'd0);
    endtask

    initial begin
        vecs[0] = '{3'b001, 3'b000, 3'b000, 48'h0000_0000_0001, 3'b000};
        vecs[1] = '{3'b000, 3'b010, 3'b000, 48'h0000_FFFF_0001, 3'b000};
        vecs[2] = '{3'b011, 3'b011, 3'b000, 48'h0000_FFFF_0001, 3'b000};
        vecs[3] = '{3'b100, 3'b000, 3'b000, 48'h0001_FFFF_0001, 3'b000};
        vecs[4] = '{3'b000, 3'b000, 3'b100, 48'h0000_FFFF_0001, 3'b000};
        vecs[5] = '{3'b100, 3'b000, 3'b100, 48'h0000_FFFF_0001, 3'b000};
        vecs[6] = '{3'b101, 3'b010, 3'b000, 48'h0001_FFFE_0002, 3'b000};

        rst_n = 1'b0;
        up = '0;
        dn = '0;
        cduz = '0;
        model_reset();
        clear_tally();

        // Reset held with inputs toggling.
        for (int k = 0; k < 5; k++)
            hold_reset_cycle(3'($urandom), 3'($urandom), 3'($urandom));
        rst_n = 1'b1;
        model_reset();
        clear_tally();
        idle(64);
        compare("post_reset_pulses", 48'(np[0] + np[1] + np[2] + nm[0] + nm[1] + nm[2]), 48'd0);

        // Constant vector table, no tick falls inside it.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].u, vecs[v].d, vecs[v].z);
            compare("table_count", count, vecs[v].exp_count);
            compare("table_sat", {45'd0, sat}, {45'd0, vecs[v].exp_sat});
            compare("table_pulses", {42'd0, pulse_p, pulse_m}, 48'd0);
        end
        applyStimulus(3'b000, 3'b000, 3'b111);
        compare("clear_all", count, 48'd0);

        // Channel 0: three ups right after a tick drain as three pulses.
        wait_after_tick();
        clear_tally();
        for (int k = 0; k < 3; k++) applyStimulus(3'b001, 3'b000, 3'b000);
        compare("ch0_count3", {32'd0, count[15:0]}, 48'd3);
        idle(3 * PD + 20);
        compare("ch0_np", 48'(np[0]), 48'd3);
        compare("ch0_quiet_others", 48'(np[1] + np[2] + nm[0] + nm[1] + nm[2]), 48'd0);

        // Channel 1 wrap below zero.
        clear_tally();
        applyStimulus(3'b000, 3'b010, 3'b000);
        compare("ch1_wrap", {32'd0, count[31:16]}, 48'h0000_0000_FFFF);
        idle(PD + 4);
        compare("ch1_nm", 48'(nm[1]), 48'd1);
        compare("ch1_np", 48'(np[1]), 48'd0);

        // Channel 2 saturation then zero with a same-cycle up.
        wait_after_tick();
        clear_tally();
        for (int k = 0; k < 10; k++) applyStimulus(3'b100, 3'b000, 3'b000);
        compare("ch2_count10", {32'd0, count[47:32]}, 48'd10);
        compare("ch2_sat", {47'd0, sat[2]}, 48'd1);
        idle(8 * PD);
        compare("ch2_np7", 48'(np[2]), 48'd7);
        applyStimulus(3'b100, 3'b000, 3'b100);
        compare("ch2_zero_count", {32'd0, count[47:32]}, 48'd0);
        compare("ch2_zero_sat", {47'd0, sat[2]}, 48'd0);
        clear_tally();
        idle(2 * PD);
        compare("ch2_no_more", 48'(np[2] + nm[2]), 48'd0);

        // Null step and emit/step collision on channel 0.
        applyStimulus(3'b001, 3'b001, 3'b000);
        compare("null_step", {32'd0, count[15:0]}, 48'd3);
        wait_after_tick();
        applyStimulus(3'b001, 3'b000, 3'b000);
        for (int k = 0; k < PD && (cyc % PD) != PD - 1; k++) idle(1);
        clear_tally();
        applyStimulus(3'b000, 3'b001, 3'b000);
        compare("collide_pp", {47'd0, pulse_p[0]}, 48'd1);
        compare("collide_count", {32'd0, count[15:0]}, 48'd3);
        idle(2 * PD + 8);
        compare("collide_np", 48'(np[0]), 48'd1);
        compare("collide_nm", 48'(nm[0]), 48'd1);

        // Asynchronous reset in the middle of a drain.
        wait_after_tick();
        for (int k = 0; k < 5; k++) applyStimulus(3'b001, 3'b000, 3'b000);
        idle(PD + 3);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare("async_count", count, 48'd0);
        compare("async_pulses", {42'd0, pulse_p, pulse_m}, 48'd0);
        compare("async_sat", {45'd0, sat}, 48'd0);
        @(negedge clk);
        hold_reset_cycle(3'b000, 3'b000, 3'b000);
        hold_reset_cycle(3'b111, 3'b000, 3'b000);
        rst_n = 1'b1;
        model_reset();
        clear_tally();
        idle(3 * PD);
        compare("after_reset_quiet", 48'(np[0] + np[1] + np[2] + nm[0] + nm[1] + nm[2]), 48'd0);

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            logic [2:0] z;
            for (int i = 0; i < NCH; i++) z[i] = ($urandom_range(0, 31) == 0);
            applyStimulus(3'($urandom), 3'($urandom), z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
